// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like bus, with an
// in-order return FIFO. Define ARB_RR_EN for round-robin instead of data-first priority.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sl_req,
  output logic        sl_wr,
  output logic [1:0]  sl_size,
  output logic [31:0] sl_addr,
  output logic [31:0] sl_wdata,
  input  logic        sl_addr_ok,
  input  logic        sl_data_ok,
  input  logic [31:0] sl_rdata,
  output logic        spurious_err
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {OWNER_INST = 1'b0, OWNER_DATA = 1'b1} owner_e;

  owner_e                 grant;
  owner_e                 lock_owner;
  logic                   lock_q;
  logic [OUTSTANDING-1:0] order_q;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   granted_req;
  logic                   head_data;

`ifdef ARB_RR_EN
  owner_e last_winner;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every path assigns grant because the default comes first; no latch.
  always_comb begin
    grant = OWNER_INST;
    if (lock_q) begin
      grant = lock_owner;
    end else if (data_req && !inst_req) begin
      grant = OWNER_DATA;
    end else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
      grant = (last_winner == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
`else
      grant = OWNER_DATA;
`endif
    end
  end

  assign full        = (count_q == CNT_W'(OUTSTANDING));
  assign empty       = (count_q == '0);
  assign granted_req = (grant == OWNER_DATA) ? data_req : inst_req;
  assign sl_req      = resetn && granted_req && !full;
  assign sl_wr       = (grant == OWNER_DATA) ? data_wr    : inst_wr;
  assign sl_size     = (grant == OWNER_DATA) ? data_size  : inst_size;
  assign sl_addr     = (grant == OWNER_DATA) ? data_addr  : inst_addr;
  assign sl_wdata    = (grant == OWNER_DATA) ? data_wdata : inst_wdata;

  assign push         = sl_req && sl_addr_ok;
  assign pop          = sl_data_ok && !empty;
  assign inst_addr_ok = push && (grant == OWNER_INST);
  assign data_addr_ok = push && (grant == OWNER_DATA);

  assign head_data    = order_q[rd_ptr];
  assign inst_data_ok = pop && !head_data;
  assign data_data_ok = pop && head_data;
  assign inst_rdata   = sl_rdata;
  assign data_rdata   = sl_rdata;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_owner <= OWNER_INST;
    end else if (sl_addr_ok) begin
      lock_q <= 1'b0;
    end else if (sl_req) begin
      lock_q     <= 1'b1;
      lock_owner <= grant;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      spurious_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (sl_data_ok && empty) spurious_err <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the count keeps stale entries from being read.
  always_ff @(posedge clk) begin
    if (push) order_q[wr_ptr] <= grant;
  end

`ifdef ARB_RR_EN
  // Reset as if data won last, so inst goes first on the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   last_winner <= OWNER_DATA;
    else if (push) last_winner <= grant;
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter against a queue-based reference model.
module tb_sram_like_arbiter;
  localparam int OUTSTANDING = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sl_req, sl_wr;
  logic [1:0]  sl_size;
  logic [31:0] sl_addr, sl_wdata;
  logic        sl_addr_ok, sl_data_ok;
  logic [31:0] sl_rdata;
  logic        spurious_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: owners in issue order (0 = inst, 1 = data).
  bit exp_q[$];
  bit m_lock, m_owner, m_last_data, m_spur;
  bit n_hs, n_g, n_lock, n_owner, n_spur;

  sram_like_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sl_req(sl_req), .sl_wr(sl_wr), .sl_size(sl_size), .sl_addr(sl_addr),
    .sl_wdata(sl_wdata), .sl_addr_ok(sl_addr_ok), .sl_data_ok(sl_data_ok),
    .sl_rdata(sl_rdata), .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lock = 0; m_owner = 0; m_spur = 0;
    m_last_data = 1;
  endtask

  // Expected combinational outputs for this cycle, plus the model's next state.
  task automatic eval_cycle();
    bit g, exp_req;
    logic [66:0] exp_fields;
    if (m_lock)                      g = m_owner;
    else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
      g = !m_last_data;
`else
      g = 1'b1;
`endif
    end else                         g = data_req;
    exp_req = (g ? data_req : inst_req) && (exp_q.size() < OUTSTANDING);
    check("sl_req", 68'(sl_req), 68'(exp_req));
    if (exp_req) begin
      exp_fields = g ? {data_wr, data_size, data_addr, data_wdata}
                     : {inst_wr, inst_size, inst_addr, inst_wdata};
      check("sl_fields", 68'({sl_wr, sl_size, sl_addr, sl_wdata}), 68'(exp_fields));
    end
    check("inst_addr_ok", 68'(inst_addr_ok), 68'(exp_req && sl_addr_ok && !g));
    check("data_addr_ok", 68'(data_addr_ok), 68'(exp_req && sl_addr_ok && g));
    check("spurious_err", 68'(spurious_err), 68'(m_spur));
    n_g     = g;
    n_hs    = exp_req && sl_addr_ok;
    n_lock  = sl_addr_ok ? 1'b0 : (exp_req ? 1'b1 : m_lock);
    n_owner = (!sl_addr_ok && exp_req) ? g : m_owner;
    n_spur  = m_spur || (sl_data_ok && exp_q.size() == 0);
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    if (n_hs) begin
      exp_q.push_back(n_g);
      m_last_data = n_g;
    end
    m_lock = n_lock; m_owner = n_owner; m_spur = n_spur;
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    sl_addr_ok = 0; sl_data_ok = 0; sl_rdata = 0;
  endtask

  task automatic drain();
    sl_addr_ok = 0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      sl_data_ok = 1; sl_rdata = $urandom;
      step();
    end
    sl_data_ok = 0;
  endtask

  // Monitor: checks return routing whenever the slave presents a response.
  initial begin
    bit owner;
    forever begin
      @(negedge clk);
      #1;
      if (resetn) begin
        if (sl_data_ok && exp_q.size() > 0) begin
          owner = exp_q.pop_front();
          check("inst_data_ok", 68'(inst_data_ok), 68'(!owner));
          check("data_data_ok", 68'(data_data_ok), 68'(owner));
          check("rdata", 68'(owner ? data_rdata : inst_rdata), 68'(sl_rdata));
        end else begin
          check("data_ok_idle", 68'({inst_data_ok, data_data_ok}), 68'(0));
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    resetn = 0;
    inst_req = 1;
    #3;
    check("reset_sl_req", 68'(sl_req), 68'(0));
    check("reset_spurious", 68'(spurious_err), 68'(0));
    check("reset_addr_ok", 68'({inst_addr_ok, data_addr_ok}), 68'(0));
    inst_req = 0;
    @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;

    // Single inst read.
    inst_req = 1; inst_addr = 32'hbfc00000; sl_addr_ok = 1;
    step();
    inst_req = 0; sl_addr_ok = 0;
    step();
    sl_data_ok = 1; sl_rdata = 32'h3c1a0001;
    step();
    sl_data_ok = 0;

    // Simultaneous requests with an always-ready slave.
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; sl_addr_ok = 1;
    step();
    if (n_g) data_req = 0; else inst_req = 0;
    step();
    inst_req = 0; data_req = 0;
    drain();

    // Lock: inst stalled while data raises req.
    inst_req = 1; inst_addr = 32'h300; sl_addr_ok = 0;
    step();
    data_req = 1; data_addr = 32'h400;
    step(); step();
    sl_addr_ok = 1;
    step();
    inst_req = 0;
    step();
    data_req = 0; sl_addr_ok = 0;
    drain();

    // FIFO full, then ordering of two responses.
    inst_req = 1; inst_addr = 32'h500; sl_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h600;
    step();
    inst_req = 1; data_req = 0; inst_addr = 32'h700;
    step();
    sl_addr_ok = 0; sl_data_ok = 1; sl_rdata = 32'h11111111;
    step();
    sl_rdata = 32'h22222222;
    step();
    sl_data_ok = 0; sl_addr_ok = 1;
    step();
    inst_req = 0; sl_addr_ok = 0;
    drain();

    // Spurious response: no master data_ok, sticky flag.
    sl_data_ok = 1; sl_rdata = 32'hdeadbeef;
    step();
    sl_data_ok = 0;
    step(); step();

    // Randomized traffic; masters hold req and payload until addr_ok.
    for (int c = 0; c < 2000; c++) begin
      if (!inst_req || (n_hs && !n_g)) begin
        inst_req = ($urandom_range(0, 2) != 0); inst_wr = 1'($urandom);
        inst_size = 2'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!data_req || (n_hs && n_g)) begin
        data_req = ($urandom_range(0, 2) != 0); data_wr = 1'($urandom);
        data_size = 2'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      sl_addr_ok = ($urandom_range(0, 9) < 7);
      sl_data_ok = (exp_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 49) == 0);
      sl_rdata = $urandom;
      if (c == 1500) begin
        // Asynchronous reset mid-transaction.
        inst_req = 1; sl_addr_ok = 0;
        step();
        resetn = 0;
        #1;
        check("midreset_sl_req", 68'(sl_req), 68'(0));
        check("midreset_spurious", 68'(spurious_err), 68'(0));
        idle_inputs();
        model_reset();
        n_hs = 0;
        @(negedge clk); #2;
        resetn = 1;
        @(posedge clk); #1;
      end
      step();
    end

    idle_inputs();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
